// File: rtl/tlb_refill_walker.sv
// tlb_refill_walker: hardware TLB miss/change handler beside the memory-stage TLB.
// Latency: miss 6+ cycles of stallM (accept, RD, WR_P, WR_V, WR_C, DONE), fault 3+,
//          change 5+ (accept, CH_RD, CH_WR, WR_CH, DONE); each cycle of mem_ack delay adds one.
// Backpressure: holds mem_req/addr/we/wdata stable until mem_ack; stalls the memory stage throughout.
//
// Ports:
//   clk, rst                      clock, async active-high reset
//   missM, changePageM            requests from the TLB (sampled only in IDLE, miss wins)
//   vpageM, hit_slotM             faulting virtual page / slot that hit (latched on accept)
//   stallM, page_fault            memory-stage freeze, one-cycle invalid-PTE pulse
//   mem_req/we/addr/wdata         memory request to the page table
//   mem_rdata, mem_ack            memory response (ack may arrive in the first request cycle)
//   tlb_we/field/slot/data        TLB field-write port
module tlb_refill_walker #(
  parameter int          COUNT_STRING = 32,
  parameter int          WIDTH_PAGE   = 20,
  parameter int          WIDTH_OFFSET = 12,
  parameter logic [31:0] PT_BASE      = 32'h0001_0000,
  localparam int         SW           = $clog2(COUNT_STRING)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  missM,
  input  logic                  changePageM,
  input  logic [WIDTH_PAGE-1:0] vpageM,
  input  logic [SW-1:0]         hit_slotM,
  output logic                  stallM,
  output logic                  page_fault,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [31:0]           mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ack,
  output logic                  tlb_we,
  output logic [1:0]            tlb_field,
  output logic [SW-1:0]         tlb_slot,
  output logic [WIDTH_PAGE-1:0] tlb_data
);

  typedef enum logic [3:0] {
    IDLE, RD, WR_P, WR_V, WR_C, FAULT, CH_RD, CH_WR, WR_CH, DONE
  } state_t;

  localparam logic [1:0] F_PPAGE  = 2'b00;
  localparam logic [1:0] F_VPAGE  = 2'b01;
  localparam logic [1:0] F_CORRECT = 2'b10;
  localparam logic [1:0] F_CHANGE = 2'b11;

  state_t                state_q, state_d;
  logic [SW-1:0]         victim_q, victim_d;
  logic [SW-1:0]         slot_q, slot_d;
  logic [WIDTH_PAGE-1:0] vpage_q, vpage_d;
  logic [31:0]           pte_q, pte_d;
  logic [31:0]           pte_addr;

  // All memory/TLB outputs decode from these registers only, so they stay
  // stable for the whole wait on mem_ack.
  assign pte_addr = PT_BASE + 32'({vpage_q, 2'b00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      victim_q <= '0;
      slot_q   <= '0;
      vpage_q  <= '0;
      pte_q    <= '0;
    end else begin
      state_q  <= state_d;
      victim_q <= victim_d;
      slot_q   <= slot_d;
      vpage_q  <= vpage_d;
      pte_q    <= pte_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    victim_d   = victim_q;
    slot_d     = slot_q;
    vpage_d    = vpage_q;
    pte_d      = pte_q;
    page_fault = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    tlb_we     = 1'b0;
    tlb_field  = F_PPAGE;
    tlb_slot   = '0;
    tlb_data   = '0;

    unique case (state_q)
      IDLE: begin
        if (missM || changePageM) begin
          vpage_d = vpageM;
          slot_d  = hit_slotM;
          state_d = missM ? RD : CH_RD;
        end
      end
      RD: begin
        mem_req  = 1'b1;
        mem_addr = pte_addr;
        if (mem_ack) begin
          pte_d   = mem_rdata;
          state_d = mem_rdata[0] ? WR_P : FAULT;
        end
      end
      WR_P: begin
        tlb_we    = 1'b1;
        tlb_field = F_PPAGE;
        tlb_slot  = victim_q;
        tlb_data  = WIDTH_PAGE'(pte_q[31:WIDTH_OFFSET]);
        state_d   = WR_V;
      end
      WR_V: begin
        tlb_we    = 1'b1;
        tlb_field = F_VPAGE;
        tlb_slot  = victim_q;
        tlb_data  = vpage_q;
        state_d   = WR_C;
      end
      WR_C: begin
        tlb_we    = 1'b1;
        tlb_field = F_CORRECT;
        tlb_slot  = victim_q;
        tlb_data  = WIDTH_PAGE'(1);
        // Round-robin replacement advances only after a completed refill.
        victim_d  = (victim_q == SW'(COUNT_STRING - 1)) ? '0 : victim_q + SW'(1);
        state_d   = DONE;
      end
      FAULT: begin
        page_fault = 1'b1;
        state_d    = IDLE;
      end
      CH_RD: begin
        mem_req  = 1'b1;
        mem_addr = pte_addr;
        if (mem_ack) begin
          pte_d   = mem_rdata;
          state_d = CH_WR;
        end
      end
      CH_WR: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = pte_addr;
        mem_wdata = pte_q | 32'h2;
        if (mem_ack) state_d = WR_CH;
      end
      WR_CH: begin
        tlb_we    = 1'b1;
        tlb_field = F_CHANGE;
        tlb_slot  = slot_q;
        tlb_data  = WIDTH_PAGE'(1);
        state_d   = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Stall covers the accept cycle combinationally; it falls the cycle after
  // DONE so the TLB re-looks-up with the new entry in IDLE.
  assign stallM = !rst && ((state_q != IDLE) || missM || changePageM);

endmodule
